pc_unit: RTL and testbench

- Program-counter stage directly downstream of the ALU in the single-cycle RV32I core.
- Consumes the ALU branch comparison flag and decoder control, and selects the next PC: sequential, branch, jal, jalr, trap or mret.
- Holds the PC register.
- Flags misaligned control-flow targets, pulses a redirect indication and counts retired instructions.

---
 rtl/pc_unit_pkg.sv | 17 +
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_JAL,
        PC_JALR,
        PC_TRAP,
        PC_MRET,
        PC_HOLD
    } next_pc_sel_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC priority select, PC register, misalign
// detection, redirect pulse and retired-instruction counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          INSTRET_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 branch_i,
    input  logic                 jal_i,
    input  logic                 jalr_i,
    input  logic                 flag_i,
    input  logic [31:0]          imm_b_i,
    input  logic [31:0]          imm_j_i,
    input  logic [31:0]          imm_i_i,
    input  logic [31:0]          rs1_i,
    input  logic                 trap_i,
    input  logic [31:0]          mtvec_i,
    input  logic                 mret_i,
    input  logic [31:0]          mepc_i,
    output logic [31:0]          pc_o,
    output logic                 redirect_o,
    output logic                 misalign_o,
    output logic [31:0]          bad_addr_o,
    output logic [INSTRET_W-1:0] instret_o
);

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    logic [31:0]          pc_q, pc_d;
    logic                 redirect_q, redirect_d;
    logic                 misalign_q, misalign_d;
    logic [31:0]          bad_addr_q;
    logic [INSTRET_W-1:0] instret_q;
    logic                 count_d;

    next_pc_sel_t sel;
    logic [31:0]  target;
    logic [31:0]  jalr_sum;

    assign jalr_sum = rs1_i + imm_i_i;

    always_comb begin
        sel = PC_SEQ;
        if (trap_i)                  sel = PC_TRAP;
        else if (mret_i)             sel = PC_MRET;
        else if (stall_i)            sel = PC_HOLD;
        else if (jalr_i)             sel = PC_JALR;
        else if (jal_i)              sel = PC_JAL;
        else if (branch_i && flag_i) sel = PC_BRANCH;
    end

    always_comb begin
        target = pc_q + PC_STEP;
        case (sel)
            PC_BRANCH: target = pc_q + imm_b_i;
            PC_JAL:    target = pc_q + imm_j_i;
            PC_JALR:   target = {jalr_sum[31:1], 1'b0};
            PC_TRAP:   target = {mtvec_i[31:2], 2'b00};
            PC_MRET:   target = {mepc_i[31:1], 1'b0};
            PC_HOLD:   target = pc_q;
            default:   target = pc_q + PC_STEP;
        endcase
    end

    // Only computed control transfers can be misaligned; trap/mret are masked.
    always_comb begin
        misalign_d = ((sel == PC_JALR) || (sel == PC_JAL) || (sel == PC_BRANCH))
                     && target[1];
        pc_d       = misalign_d ? pc_q : target;
        redirect_d = !misalign_d && (sel != PC_SEQ) && (sel != PC_HOLD);
        count_d    = !stall_i && !trap_i && !misalign_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= 32'h0;
            instret_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            if (misalign_d) begin
                bad_addr_q <= target;
            end
            if (count_d) begin
                instret_q <= instret_q + INSTRET_ONE;
            end
        end
    end

    assign pc_o       = pc_q;
    assign redirect_o = redirect_q;
    assign misalign_o = misalign_q;
    assign bad_addr_o = bad_addr_q;
    assign instret_o  = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit, with a narrow-counter instance
// used to exercise instret wrap-around.
module tb_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, branch_i, jal_i, jalr_i, flag_i, trap_i, mret_i;
    logic [31:0] imm_b_i, imm_j_i, imm_i_i, rs1_i, mtvec_i, mepc_i;
    logic [31:0] pc_o, bad_addr_o;
    logic        redirect_o, misalign_o;
    logic [63:0] instret_o;

    logic        zero_b = 1'b0;
    logic [31:0] zero_w = 32'h0;
    logic [31:0] pc_w, bad_addr_w;
    logic        redirect_w, misalign_w;
    logic [2:0]  instret_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    pc_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
        .jal_i(jal_i), .jalr_i(jalr_i), .flag_i(flag_i), .imm_b_i(imm_b_i),
        .imm_j_i(imm_j_i), .imm_i_i(imm_i_i), .rs1_i(rs1_i), .trap_i(trap_i),
        .mtvec_i(mtvec_i), .mret_i(mret_i), .mepc_i(mepc_i), .pc_o(pc_o),
        .redirect_o(redirect_o), .misalign_o(misalign_o),
        .bad_addr_o(bad_addr_o), .instret_o(instret_o)
    );

    pc_unit #(.INSTRET_W(3)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(zero_b), .branch_i(zero_b),
        .jal_i(zero_b), .jalr_i(zero_b), .flag_i(zero_b), .imm_b_i(zero_w),
        .imm_j_i(zero_w), .imm_i_i(zero_w), .rs1_i(zero_w), .trap_i(zero_b),
        .mtvec_i(zero_w), .mret_i(zero_b), .mepc_i(zero_w), .pc_o(pc_w),
        .redirect_o(redirect_w), .misalign_o(misalign_w),
        .bad_addr_o(bad_addr_w), .instret_o(instret_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        stall_i = 0; branch_i = 0; jal_i = 0; jalr_i = 0; flag_i = 0;
        trap_i = 0; mret_i = 0;
        imm_b_i = 0; imm_j_i = 0; imm_i_i = 0; rs1_i = 0; mtvec_i = 0; mepc_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc,
                                input logic redir, input logic [63:0] ir);
        check({tag, ".pc"}, pc_o, pc);
        check({tag, ".redirect"}, redirect_o, redir);
        check({tag, ".instret"}, instret_o, ir);
    endtask

    initial begin
        clr();
        rst_i = 1'b1;
        #12;
        check("rst.pc", pc_o, 32'h0);
        check("rst.redirect", redirect_o, 1'b0);
        check("rst.misalign", misalign_o, 1'b0);
        check("rst.bad_addr", bad_addr_o, 32'h0);
        check("rst.instret", instret_o, 64'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        step(); expect_state("seq1", 32'h4, 1'b0, 64'd1);
        step(); expect_state("seq2", 32'h8, 1'b0, 64'd2);
        step(); expect_state("seq3", 32'hC, 1'b0, 64'd3);

        jal_i = 1; imm_j_i = 32'hF4;
        step(); expect_state("jal_to_100", 32'h100, 1'b1, 64'd4);

        clr(); branch_i = 1; flag_i = 1; imm_b_i = 32'hFFFF_FFF0;
        step(); expect_state("br_taken", 32'hF0, 1'b1, 64'd5);
        clr();
        step(); expect_state("after_br", 32'hF4, 1'b0, 64'd6);

        jal_i = 1; imm_j_i = 32'h0C;
        step(); expect_state("jal_back", 32'h100, 1'b1, 64'd7);
        clr(); branch_i = 1; flag_i = 0; imm_b_i = 32'hFFFF_FFF0;
        step(); expect_state("br_not_taken", 32'h104, 1'b0, 64'd8);

        clr(); jalr_i = 1; rs1_i = 32'h2001;
        step(); expect_state("jalr_lsb", 32'h2000, 1'b1, 64'd9);
        rs1_i = 32'h2002;
        step(); expect_state("jalr_mis", 32'h2000, 1'b0, 64'd9);
        check("jalr_mis.misalign", misalign_o, 1'b1);
        check("jalr_mis.bad_addr", bad_addr_o, 32'h2002);
        clr();
        step(); expect_state("post_mis", 32'h2004, 1'b0, 64'd10);
        check("post_mis.misalign", misalign_o, 1'b0);
        check("post_mis.bad_addr", bad_addr_o, 32'h2002);

        jal_i = 1; imm_j_i = 32'hFFFF_E03C;
        step(); expect_state("jal_to_40", 32'h40, 1'b1, 64'd11);
        clr(); stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_state($sformatf("stall%0d", i), 32'h40, 1'b0, 64'd11);
        end
        trap_i = 1; mtvec_i = 32'h8003;
        step(); expect_state("trap_in_stall", 32'h8000, 1'b1, 64'd11);

        clr(); trap_i = 1; mret_i = 1; jal_i = 1;
        mtvec_i = 32'h8003; mepc_i = 32'h500; imm_j_i = 32'h10;
        step(); expect_state("trap_prio", 32'h8000, 1'b1, 64'd11);
        clr(); mret_i = 1; mepc_i = 32'h304;
        step(); expect_state("mret", 32'h304, 1'b1, 64'd12);
        check("mret.misalign", misalign_o, 1'b0);

        clr(); branch_i = 1; flag_i = 1; imm_b_i = 32'h2;
        step(); expect_state("br_mis", 32'h304, 1'b0, 64'd12);
        check("br_mis.misalign", misalign_o, 1'b1);
        check("br_mis.bad_addr", bad_addr_o, 32'h306);
        flag_i = 0;
        step(); expect_state("br_nt_odd_imm", 32'h308, 1'b0, 64'd13);
        check("br_nt_odd_imm.misalign", misalign_o, 1'b0);

        clr(); jalr_i = 1; rs1_i = 32'hFFFF_FFFC;
        step(); expect_state("jalr_top", 32'hFFFF_FFFC, 1'b1, 64'd14);
        clr();
        step(); expect_state("pc_wrap", 32'h0, 1'b0, 64'd15);
        step(); expect_state("pc_after_wrap", 32'h4, 1'b0, 64'd16);

        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst.pc", pc_o, 32'h0);
        check("async_rst.instret", instret_o, 64'd0);
        check("async_rst.bad_addr", bad_addr_o, 32'h0);
        check("async_rst.narrow_instret", {61'd0, instret_w}, 64'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 1; i <= 7; i++) step();
        check("narrow.all_ones", {61'd0, instret_w}, 64'd7);
        check("narrow.pc", pc_w, 32'h1C);
        step();
        check("narrow.wrap", {61'd0, instret_w}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
